// File: rtl/alu_exec_unit.sv
`timescale 1ns/1ps
// alu_exec_unit: single-issue integer execute unit. It covers the RV base ALU, plus the
// M extension when M_EN != 0. Multiplies finish in one cycle. Divides and remainders use
// an XLEN-cycle restoring divider.
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   in_valid/ready   operation handshake
//   ALUop, funct3, funct75, funct70, op5
//                    decode fields for the operation
//   src_a, src_b     operands
//   flush            abort any in-flight operation and drop the held result
//   out_valid/ready  result handshake
//   result, zero, illegal
//                    registered result payload
module alu_exec_unit #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned M_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUop,
    input  logic [2:0]      funct3,
    input  logic            funct75,
    input  logic            funct70,
    input  logic            op5,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned PW  = 2 * XLEN;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_HOLD} state_e;
    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    state_e          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;
    logic            is_rem_q, is_rem_d;

    op_e             op_c;
    logic            ill_c;
    logic [SHW-1:0]  shamt_c;
    logic [PW-1:0]   mul_a_c, mul_b_c, prod_c;
    logic            is_div_c, is_rem_c, sdiv_c, div_zero_c, div_ovf_c;
    logic            a_neg_c, b_neg_c;
    logic [XLEN-1:0] a_mag_c, b_mag_c;
    logic [XLEN-1:0] alu_res_c, exec_res_c;
    logic [XLEN:0]   r_sh_c, diff_c;
    logic [XLEN-1:0] quo_step_c, rem_step_c, div_res_c;
    logic            accept_c;

    // Decode: illegal encodings fall back to add with the illegal flag set.
    always_comb begin
        op_c  = OP_ADD;
        ill_c = 1'b0;
        case (ALUop)
            2'b00: op_c = OP_ADD;
            2'b01: op_c = OP_SUB;
            2'b10: begin
                if (op5 && funct70) begin
                    if (M_EN != 0) begin
                        case (funct3)
                            3'b000:  op_c = OP_MUL;
                            3'b001:  op_c = OP_MULH;
                            3'b010:  op_c = OP_MULHSU;
                            3'b011:  op_c = OP_MULHU;
                            3'b100:  op_c = OP_DIV;
                            3'b101:  op_c = OP_DIVU;
                            3'b110:  op_c = OP_REM;
                            default: op_c = OP_REMU;
                        endcase
                    end else begin
                        ill_c = 1'b1;
                    end
                end else begin
                    case (funct3)
                        3'b000:  op_c = (op5 && funct75) ? OP_SUB : OP_ADD;
                        3'b001:  op_c = OP_SLL;
                        3'b010:  op_c = OP_SLT;
                        3'b011:  op_c = OP_SLTU;
                        3'b100:  op_c = OP_XOR;
                        3'b101:  op_c = funct75 ? OP_SRA : OP_SRL;
                        3'b110:  op_c = OP_OR;
                        default: op_c = OP_AND;
                    endcase
                    // funct75 only selects sub/sra. On I-type it is an immediate bit,
                    // except for slli, where it must be zero.
                    if (funct75 && ((funct3 == 3'b001) ||
                        (op5 && (funct3 != 3'b000) && (funct3 != 3'b101)))) begin
                        ill_c = 1'b1;
                        op_c  = OP_ADD;
                    end
                end
            end
            default: ill_c = 1'b1;
        endcase
    end

    // Single-cycle datapath, including the divide early-outs.
    always_comb begin
        shamt_c    = src_b[SHW-1:0];
        mul_a_c    = ((op_c == OP_MULH) || (op_c == OP_MULHSU)) ?
                     {{XLEN{src_a[XLEN-1]}}, src_a} : {{XLEN{1'b0}}, src_a};
        mul_b_c    = (op_c == OP_MULH) ? {{XLEN{src_b[XLEN-1]}}, src_b} : {{XLEN{1'b0}}, src_b};
        prod_c     = mul_a_c * mul_b_c;
        is_div_c   = (op_c == OP_DIV) || (op_c == OP_DIVU) || (op_c == OP_REM) || (op_c == OP_REMU);
        is_rem_c   = (op_c == OP_REM) || (op_c == OP_REMU);
        sdiv_c     = (op_c == OP_DIV) || (op_c == OP_REM);
        div_zero_c = (src_b == '0);
        div_ovf_c  = sdiv_c && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
        a_neg_c    = sdiv_c && src_a[XLEN-1];
        b_neg_c    = sdiv_c && src_b[XLEN-1];
        a_mag_c    = a_neg_c ? -src_a : src_a;
        b_mag_c    = b_neg_c ? -src_b : src_b;

        case (op_c)
            OP_SUB:    alu_res_c = src_a - src_b;
            OP_SLL:    alu_res_c = src_a << shamt_c;
            OP_SLT:    alu_res_c = XLEN'($signed(src_a) < $signed(src_b));
            OP_SLTU:   alu_res_c = XLEN'(src_a < src_b);
            OP_XOR:    alu_res_c = src_a ^ src_b;
            OP_SRL:    alu_res_c = src_a >> shamt_c;
            OP_SRA:    alu_res_c = XLEN'($signed(src_a) >>> shamt_c);
            OP_OR:     alu_res_c = src_a | src_b;
            OP_AND:    alu_res_c = src_a & src_b;
            OP_MUL:    alu_res_c = prod_c[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  alu_res_c = prod_c[PW-1:XLEN];
            default:   alu_res_c = src_a + src_b;
        endcase

        // Only the divide-by-zero and signed-overflow cases reach the result mux
        // directly; every other divide goes through the iterative divider.
        if (is_div_c) begin
            if (div_zero_c) begin
                exec_res_c = is_rem_c ? src_a : '1;
            end else begin
                exec_res_c = is_rem_c ? '0 : src_a;
            end
        end else begin
            exec_res_c = alu_res_c;
        end
    end

    // One restoring-division step: shift in the next dividend bit, then subtract if it fits.
    always_comb begin
        r_sh_c = {rem_q, quo_q[XLEN-1]};
        diff_c = r_sh_c - {1'b0, divisor_q};
        if (!diff_c[XLEN]) begin
            rem_step_c = diff_c[XLEN-1:0];
            quo_step_c = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_step_c = r_sh_c[XLEN-1:0];
            quo_step_c = {quo_q[XLEN-2:0], 1'b0};
        end
        if (is_rem_q) begin
            div_res_c = neg_rem_q ? -rem_step_c : rem_step_c;
        end else begin
            div_res_c = neg_quot_q ? -quo_step_c : quo_step_c;
        end
    end

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept_c = in_valid && in_ready && !flush;

    // Next-state and result-register update.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        divisor_d   = divisor_q;
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
        is_rem_d    = is_rem_q;

        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                    end
                    if (accept_c) begin
                        if (is_div_c && !div_zero_c && !div_ovf_c) begin
                            state_d     = S_DIV;
                            out_valid_d = 1'b0;
                            cnt_d       = '0;
                            quo_d       = a_mag_c;
                            rem_d       = '0;
                            divisor_d   = b_mag_c;
                            neg_quot_d  = a_neg_c ^ b_neg_c;
                            neg_rem_d   = a_neg_c;
                            is_rem_d    = is_rem_c;
                        end else begin
                            out_valid_d = 1'b1;
                            result_d    = exec_res_c;
                            zero_d      = (exec_res_c == '0);
                            illegal_d   = ill_c;
                        end
                    end
                end
                S_DIV: begin
                    quo_d = quo_step_c;
                    rem_d = rem_step_c;
                    cnt_d = cnt_q + SHW'(1);
                    if (cnt_q == SHW'(XLEN - 1)) begin
                        state_d     = S_HOLD;
                        cnt_d       = '0;
                        out_valid_d = 1'b1;
                        result_d    = div_res_c;
                        zero_d      = (div_res_c == '0);
                        illegal_d   = 1'b0;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            illegal_q   <= 1'b0;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            divisor_q   <= '0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            is_rem_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            divisor_q   <= divisor_d;
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
            is_rem_q    <= is_rem_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
`timescale 1ns/1ps
// Scoreboarded bench for alu_exec_unit (XLEN=32). Expected results come from an arithmetic
// reference model; a separate negedge monitor checks value, latency and hold stability.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, funct75, funct70, op5, flush;
    logic        out_valid, out_ready, zero, illegal;
    logic [1:0]  aluop;
    logic [2:0]  funct3;
    logic [31:0] src_a, src_b, result;

    logic        m_in_valid, m_in_ready, m_funct75, m_funct70, m_op5, m_flush;
    logic        m_out_valid, m_out_ready, m_zero, m_illegal;
    logic [1:0]  m_aluop;
    logic [2:0]  m_funct3;
    logic [31:0] m_src_a, m_src_b, m_result;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    bit   head_seen = 1'b0;
    bit   rdy_rand  = 1'b0;
    int   cyc       = 0;
    int   n_chk     = 0;
    int   n_err     = 0;

    alu_exec_unit #(.XLEN(32), .M_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUop(aluop), .funct3(funct3), .funct75(funct75), .funct70(funct70), .op5(op5),
        .src_a(src_a), .src_b(src_b), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
    );

    alu_exec_unit #(.XLEN(32), .M_EN(0)) u_dut_nom (
        .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .ALUop(m_aluop), .funct3(m_funct3), .funct75(m_funct75), .funct70(m_funct70),
        .op5(m_op5), .src_a(m_src_a), .src_b(m_src_b), .flush(m_flush),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .result(m_result),
        .zero(m_zero), .illegal(m_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: RISC-V semantics computed with plain integer arithmetic.
    function automatic void model(input logic [1:0] aop, input logic [2:0] f3,
                                  input logic f75, input logic f70, input logic o5,
                                  input logic [31:0] a, input logic [31:0] b, input bit m_en,
                                  output logic [31:0] res, output logic ill, output int lat);
        int     sa, sb, sh;
        longint la, lb, ua, ub, p;
        bit     ovf, legal;
        sa  = $signed(a);
        sb  = $signed(b);
        la  = longint'(sa);
        lb  = longint'(sb);
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        sh  = int'(b[4:0]);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        res = a + b;
        ill = 1'b0;
        lat = 1;
        if (aop == 2'b01) begin
            res = a - b;
        end else if (aop == 2'b11) begin
            ill = 1'b1;
        end else if (aop == 2'b10) begin
            if (o5 && f70) begin
                if (!m_en) begin
                    ill = 1'b1;
                end else begin
                    case (f3)
                        3'd0: begin p = la * lb; res = p[31:0]; end
                        3'd1: begin p = la * lb; res = p[63:32]; end
                        3'd2: begin p = la * ub; res = p[63:32]; end
                        3'd3: begin p = ua * ub; res = p[63:32]; end
                        3'd4: if (b == 0) res = 32'hFFFF_FFFF;
                              else if (ovf) res = a;
                              else begin res = 32'(sa / sb); lat = 33; end
                        3'd5: if (b == 0) res = 32'hFFFF_FFFF;
                              else begin res = a / b; lat = 33; end
                        3'd6: if (b == 0) res = a;
                              else if (ovf) res = 32'd0;
                              else begin res = 32'(sa % sb); lat = 33; end
                        default: if (b == 0) res = a;
                                 else begin res = a % b; lat = 33; end
                    endcase
                end
            end else begin
                legal = !f75 || (f3 == 3'd5) || (!o5 && f3 != 3'd1) || (o5 && f3 == 3'd0);
                if (!legal) begin
                    ill = 1'b1;
                end else begin
                    case (f3)
                        3'd0: res = (o5 && f75) ? a - b : a + b;
                        3'd1: res = a << sh;
                        3'd2: res = (sa < sb) ? 32'd1 : 32'd0;
                        3'd3: res = (a < b) ? 32'd1 : 32'd0;
                        3'd4: res = a ^ b;
                        3'd5: res = f75 ? 32'(sa >>> sh) : a >> sh;
                        3'd6: res = a | b;
                        default: res = a & b;
                    endcase
                end
            end
        end
    endfunction

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic [1:0] aop, input logic [2:0] f3, input logic f75,
                         input logic f70, input logic o5, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        aluop = aop; funct3 = f3; funct75 = f75; funct70 = f70; op5 = o5;
        src_a = a; src_b = b; in_valid = 1'b1;
        for (int i = 0; ; i++) begin
            @(negedge clk);
            if (in_ready) break;
            if (i >= 200) begin
                chk("in_ready_timeout", 64'(in_ready), 64'(1));
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        model(aop, f3, f75, f70, o5, a, b, 1'b1, e.res, e.ill, e.lat);
        e.zero = (e.res == 32'd0);
        e.acc  = cyc;
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        chk("drain_timeout", 64'(sb_q.size()), 64'(0));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: checks the head entry every cycle it is presented, pops on handshake.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_out_valid", 64'(out_valid), 64'(0));
            end else begin
                if (!head_seen) begin
                    chk("latency", 64'(cyc - sb_q[0].acc), 64'(sb_q[0].lat));
                    head_seen = 1'b1;
                end
                chk("result", 64'(result), 64'(sb_q[0].res));
                chk("zero", 64'(zero), 64'(sb_q[0].zero));
                chk("illegal", 64'(illegal), 64'(sb_q[0].ill));
                if (out_ready) begin
                    void'(sb_q.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mres;
        logic        mill;
        int          mlat;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        aluop = 2'b00; funct3 = 3'd0; funct75 = 1'b0; funct70 = 1'b0; op5 = 1'b0;
        src_a = 32'd0; src_b = 32'd0;
        m_in_valid = 1'b0; m_flush = 1'b0; m_out_ready = 1'b1;
        m_aluop = 2'b00; m_funct3 = 3'd0; m_funct75 = 1'b0; m_funct70 = 1'b0; m_op5 = 1'b0;
        m_src_a = 32'd0; m_src_b = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_zero", 64'(zero), 64'(1));
        chk("rst_illegal", 64'(illegal), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Directed: sub, divides, early-out divides, reserved ALUop.
        issue(2'b10, 3'd0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7);
        issue(2'b10, 3'd5, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7);
        drain();
        issue(2'b10, 3'd6, 1'b0, 1'b1, 1'b1, -32'd100, 32'd7);
        drain();
        issue(2'b10, 3'd4, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'b10, 3'd5, 1'b0, 1'b1, 1'b1, 32'd9, 32'd0);
        issue(2'b11, 3'd0, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4);
        issue(2'b10, 3'd1, 1'b1, 1'b0, 1'b0, 32'd3, 32'd4);
        drain();

        // Backpressure on an add result, then back-to-back handoff.
        out_ready = 1'b0;
        issue(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 32'd11, 32'd22);
        repeat (5) begin
            @(negedge clk);
            chk("hold_in_ready", 64'(in_ready), 64'(0));
            chk("hold_out_valid", 64'(out_valid), 64'(1));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        issue(2'b01, 3'd0, 1'b0, 1'b0, 1'b0, 32'd50, 32'd8);
        drain();

        // Flush at DIV cycle 10.
        issue(2'b10, 3'd5, 1'b0, 1'b1, 1'b1, 32'd1000, 32'd3);
        repeat (9) begin
            @(negedge clk);
            chk("div_in_ready", 64'(in_ready), 64'(0));
            @(posedge clk); #1;
        end
        flush = 1'b1;
        sb_q.delete();
        head_seen = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_in_ready", 64'(in_ready), 64'(1));
        repeat (40) @(posedge clk);
        #1;

        // Flush wins over a simultaneous in_valid.
        aluop = 2'b00; src_a = 32'd1; src_b = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_no_accept", 64'(out_valid), 64'(0));
        @(posedge clk); #1;

        // Reset mid-DIV.
        issue(2'b10, 3'd4, 1'b0, 1'b1, 1'b1, -32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        sb_q.delete();
        head_seen = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstdiv_out_valid", 64'(out_valid), 64'(0));
        chk("rstdiv_result", 64'(result), 64'(0));
        chk("rstdiv_zero", 64'(zero), 64'(1));
        chk("rstdiv_in_ready", 64'(in_ready), 64'(1));
        repeat (40) @(posedge clk);
        #1;

        // M_EN=0 instance: mul and div encodings decode as an illegal add.
        for (int k = 0; k < 2; k++) begin
            m_aluop = 2'b10; m_funct3 = (k == 0) ? 3'd0 : 3'd4; m_funct75 = 1'b0;
            m_funct70 = 1'b1; m_op5 = 1'b1; m_src_a = 32'd6 + 32'(k * 94); m_src_b = 32'd7;
            m_in_valid = 1'b1;
            model(m_aluop, m_funct3, m_funct75, m_funct70, m_op5, m_src_a, m_src_b, 1'b0,
                  mres, mill, mlat);
            @(negedge clk);
            chk("nom_in_ready", 64'(m_in_ready), 64'(1));
            @(posedge clk); #1;
            m_in_valid = 1'b0;
            @(negedge clk);
            chk("nom_out_valid", 64'(m_out_valid), 64'(mlat));
            chk("nom_result", 64'(m_result), 64'(mres));
            chk("nom_illegal", 64'(m_illegal), 64'(mill));
            chk("nom_zero", 64'(m_zero), 64'(mres == 32'd0));
            @(posedge clk); #1;
        end

        // Randomised traffic with random backpressure.
        rdy_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [1:0] ra;
            ra = ($urandom_range(0, 9) < 7) ? 2'b10 : 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            issue(ra, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  pick_operand(), pick_operand());
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving operand/result width (legal: 32, 64).
REQ-002 The block SHALL have parameter M_EN, default 1; when 0, M-extension encodings SHALL be decoded as illegal.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operation presented.
REQ-006 in_ready  output  1  block accepts operation this cycle.
REQ-007 ALUop  input  2  00 add (load/store), 01 sub (branch), 10 R/I decode, 11 reserved.
REQ-008 funct3  input  3  instruction funct3.
REQ-009 funct75  input  1  instruction bit 30 (sub/sra select).
REQ-010 funct70  input  1  instruction bit 25 (M-extension select).
REQ-011 op5  input  1  opcode bit 5 (1 = R-type, 0 = I-type).
REQ-012 src_a, src_b  input  XLEN each  operands.
REQ-013 flush  input  1  abort in-flight operation.
REQ-014 out_valid  output  1  result register holds valid data.
REQ-015 out_ready  input  1  consumer takes result.
REQ-016 result  output  XLEN  operation result.
REQ-017 zero  output  1  result == 0.
REQ-018 illegal  output  1  accepted encoding was not in the decode table; qualified by out_valid.

Function
REQ-019 Accept SHALL occur when in_valid && in_ready && !flush; in_ready SHALL be 1 only in IDLE with out_valid==0 or out_ready==1.
REQ-020 ALUop 00 SHALL give add, 01 sub, 11 add with illegal=1.
REQ-021 ALUop 10 SHALL decode funct3: 000 add (sub if op5&&funct75), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl (sra if funct75), 110 or, 111 and.
REQ-022 ALUop 10, op5=1, funct70=1, M_EN=1 SHALL decode funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-023 Any other ALUop 10 combination (e.g. funct75=1 with funct3 not 000/101 when op5=1, funct75=1 with funct3 001 on I-type) SHALL execute add and set illegal=1.
REQ-024 Shift amount SHALL be src_b[$clog2(XLEN)-1:0]; slt/sltu SHALL return zero-extended 0/1.
REQ-025 mul variants SHALL produce low (mul) or high XLEN bits of the 2*XLEN product with the signedness of the RISC-V spec.
REQ-026 FSM states: IDLE, DIV, HOLD.
REQ-027 Non-divide op accepted in IDLE SHALL load result next edge: out_valid=1 one cycle after accept (latency 1), state stays IDLE.
REQ-028 Divide/rem accepted SHALL go to DIV, run a restoring divider one quotient bit per cycle for XLEN cycles, then load result and go to HOLD; out_valid SHALL rise XLEN+1 cycles after accept.
REQ-029 Divisor 0 SHALL complete with latency 1 (no DIV): quotient all-ones, remainder = src_a.
REQ-030 Signed overflow (src_a = most-negative, src_b = -1) SHALL complete with latency 1: quotient = src_a, remainder 0.
REQ-031 Signed div/rem SHALL operate on magnitudes; quotient sign = sign(a) xor sign(b), remainder sign = sign(a).
REQ-032 HOLD SHALL return to IDLE when out_ready=1 with out_valid=1; while out_valid && !out_ready, result/zero/illegal SHALL stay stable.
REQ-033 Result handoff: out_valid && out_ready in the same cycle as a new accept SHALL replace result back-to-back with no bubble.
REQ-034 flush SHALL, next edge, clear out_valid, abort DIV, and force IDLE; flush SHALL win over a simultaneous in_valid (no accept).
REQ-035 in_ready SHALL be 0 throughout DIV and HOLD.

Reset
REQ-036 rst_n=0 sampled at a clock edge SHALL force IDLE, out_valid=0, result=0, zero=1, illegal=0, divider counter=0; in_ready SHALL be 1 one cycle after rst_n returns high.
REQ-037 Reset mid-DIV SHALL discard the operation without producing out_valid.

Verification
REQ-038 ALUop=10, op5=1, funct3=000, funct75=1, a=5, b=7, out_ready=1 -> next cycle out_valid=1, result=0xFFFFFFFE, zero=0, illegal=0.
REQ-039 divu a=100, b=7 -> out_valid at accept+33, result=14; rem a=-100, b=7 -> result=-2 (0xFFFFFFFE).
REQ-040 div a=0x80000000, b=0xFFFFFFFF -> result 0x80000000 at accept+1; divu a=9, b=0 -> 0xFFFFFFFF at accept+1.
REQ-041 out_ready=0 for 5 cycles after add result -> result stable, in_ready=0; raise out_ready with new in_valid -> back-to-back accept, new result next cycle.
REQ-042 flush at DIV cycle 10 -> out_valid stays 0, in_ready=1 next cycle; rst_n=0 mid-DIV -> same, result=0.
REQ-043 ALUop=11 a=3, b=4 -> result=7, illegal=1; M_EN=0 with mul encoding -> result=a+b, illegal=1.
